// File: rtl/menu_box_writer.sv
// Walks every pixel of the menu-centre box and issues one framebuffer write per pixel.
// The box position is a linear start address. Each row advances by adding the screen width, so no multiplier is used.
module menu_box_writer #(
    parameter int SCREEN_W  = 640,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8,
    parameter int ROW_FIRST = 7,
    parameter int ROW_LAST  = 22,
    parameter int COL_FIRST = 8,
    parameter int COL_LAST  = 22
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startaddr,
    input  logic [DATA_W-1:0] color_in,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(((ROW_LAST > COL_LAST) ? ROW_LAST : COL_LAST) + 2);

    localparam logic [ADDR_W-1:0] ROW_OFFSET = ADDR_W'(ROW_FIRST * SCREEN_W);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);
    localparam logic [ADDR_W-1:0] COL_OFFSET = ADDR_W'(COL_FIRST);
    localparam logic [CNT_W-1:0]  ROW_MIN    = CNT_W'(ROW_FIRST);
    localparam logic [CNT_W-1:0]  ROW_MAX    = CNT_W'(ROW_LAST);
    localparam logic [CNT_W-1:0]  COL_MIN    = CNT_W'(COL_FIRST);
    localparam logic [CNT_W-1:0]  COL_MAX    = CNT_W'(COL_LAST);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        DONE
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] row_base;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  col;
    logic [ADDR_W-1:0] start_base;

    assign start_base = startaddr + ROW_OFFSET;

    // wr_data holds the latched colour for the whole fill.
    // wr_addr is precomputed one step ahead, so the outputs only change on a consumed write.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            row_base <= '0;
            row      <= '0;
            col      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        row_base <= start_base;
                        row      <= ROW_MIN;
                        col      <= COL_MIN;
                        wr_en    <= 1'b1;
                        wr_addr  <= start_base + COL_OFFSET;
                        wr_data  <= color_in;
                        busy     <= 1'b1;
                        state    <= DRAW;
                    end
                end
                DRAW: begin
                    if (wr_ready) begin
                        if (col < COL_MAX) begin
                            col     <= col + 1'b1;
                            wr_addr <= row_base + ADDR_W'(col) + ADDR_W'(1);
                        end else if (row < ROW_MAX) begin
                            col      <= COL_MIN;
                            row      <= row + 1'b1;
                            row_base <= row_base + ROW_STRIDE;
                            wr_addr  <= row_base + ROW_STRIDE + COL_OFFSET;
                        end else begin
                            wr_en <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    wr_en <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_menu_box_writer.sv
// Self-checking bench for menu_box_writer.
// The expected write addresses come from the box geometry, so every fill is compared against an address list computed directly from the start address.
module tb_menu_box_writer;

    localparam int SCREEN_W  = 640;
    localparam int ADDR_W    = 19;
    localparam int DATA_W    = 8;
    localparam int ROW_FIRST = 7;
    localparam int ROW_LAST  = 22;
    localparam int COL_FIRST = 8;
    localparam int COL_LAST  = 22;
    localparam int NPIX      = (ROW_LAST - ROW_FIRST + 1) * (COL_LAST - COL_FIRST + 1);

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] startaddr;
    logic [DATA_W-1:0] color_in;
    logic              wr_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    logic [ADDR_W-1:0] expq[$];

    menu_box_writer #(
        .SCREEN_W(SCREEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROW_FIRST(ROW_FIRST), .ROW_LAST(ROW_LAST),
        .COL_FIRST(COL_FIRST), .COL_LAST(COL_LAST)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .startaddr(startaddr),
        .color_in(color_in), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every pixel of the box, in raster order, wrapped to the address width
    task automatic buildExpected(input logic [ADDR_W-1:0] addr);
        expq.delete();
        for (int r = ROW_FIRST; r <= ROW_LAST; r++)
            for (int c = COL_FIRST; c <= COL_LAST; c++)
                expq.push_back(ADDR_W'((int'(addr) + r * SCREEN_W + c) % (1 << ADDR_W)));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_wr_en"}, 32'(wr_en), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
    endtask

    // mode: 0 ready always, 1 ready pattern 1,0,0, 2 random ready
    task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] color,
                                 input int mode, input bit holdStart, input int abortAt);
        int idx;
        int k;
        buildExpected(addr);
        startaddr = addr;
        color_in  = color;
        start     = 1'b1;
        wr_ready  = 1'($urandom % 2);
        step();
        start = holdStart;
        idx = 0;
        k = 0;
        while (idx < NPIX && k < 4000) begin
            if (abortAt > 0 && idx == abortAt) begin
                #2 reset = 1'b1;
                #1;
                checkIdle("async_reset");
                checkOutput("async_reset_addr", 32'(wr_addr), 32'd0);
                checkOutput("async_reset_data", 32'(wr_data), 32'd0);
                start = 1'b0;
                @(posedge clock);
                #1;
                reset = 1'b0;
                step();
                checkIdle("after_reset");
                return;
            end
            checkOutput("draw_wr_en", 32'(wr_en), 32'd1);
            checkOutput("draw_addr", 32'(wr_addr), 32'(expq[idx]));
            checkOutput("draw_data", 32'(wr_data), 32'(color));
            checkOutput("draw_busy", 32'(busy), 32'd1);
            checkOutput("draw_done", 32'(done), 32'd0);
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = (k % 3 == 0);
                default: wr_ready = 1'($urandom % 2);
            endcase
            startaddr = ADDR_W'($urandom);
            color_in  = DATA_W'($urandom);
            if (!holdStart) start = 1'($urandom % 2);
            if (idx == 100 && !holdStart) begin
                start     = 1'b1;
                startaddr = ADDR_W'(1000);
                color_in  = 8'hFF;
            end
            if (wr_ready) idx++;
            k++;
            step();
        end
        if (idx < NPIX) begin
            checkOutput("fill_timeout", 32'(idx), 32'(NPIX));
            return;
        end
        checkOutput("done_pulse", 32'(done), 32'd1);
        checkOutput("done_wr_en", 32'(wr_en), 32'd0);
        checkOutput("done_busy", 32'(busy), 32'd1);
        start = holdStart ? 1'b1 : 1'($urandom % 2);
        step();
        checkIdle("post_done");
        start = holdStart;
        if (!holdStart) begin
            step();
            checkIdle("stay_idle");
        end
    endtask

    initial begin
        logic [ADDR_W-1:0] a;
        reset     = 1'b1;
        start     = 1'b0;
        startaddr = '0;
        color_in  = '0;
        wr_ready  = 1'b0;
        #2;
        checkIdle("reset");
        checkOutput("reset_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_data", 32'(wr_data), 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        checkIdle("reset_release");

        $display("[TB] basic fill");
        applyStimulus('0, 8'h3C, 0, 1'b0, 0);
        $display("[TB] backpressure fill");
        applyStimulus('0, 8'h3C, 1, 1'b0, 0);

        $display("[TB] reset mid-fill");
        a = ADDR_W'($urandom);
        applyStimulus(a, 8'h5A, 2, 1'b0, 50);
        applyStimulus(a, 8'hA5, 0, 1'b0, 0);

        $display("[TB] wrap-around");
        applyStimulus(ADDR_W'((1 << ADDR_W) - 100), DATA_W'($urandom), 2, 1'b0, 0);

        $display("[TB] back-to-back");
        applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 0, 1'b1, 0);
        applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 2, 1'b1, 0);
        applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 0, 1'b0, 0);

        $display("[TB] random fills");
        for (int i = 0; i < 3; i++)
            applyStimulus(ADDR_W'($urandom), DATA_W'($urandom), 2, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/menu_box_writer.md
Name: menu_box_writer

Overview:
- Sequential counterpart of the combinational menu-centre hit test: instead of testing a pixel address against the box, it walks every pixel of the box and emits framebuffer write requests.
- Fills the box with a solid colour so the menu centre can be drawn into video memory rather than overlaid per pixel.
- Box geometry matches the hit test exactly: rows 7..22 and columns 8..22 relative to a 19-bit linear start address on a 640-pixel-wide screen.
- The block sits between the menu/game control logic (start/done) and the framebuffer write port (valid/ready).

Parameters:
- SCREEN_W, 640, pixels per row; the row stride in address units.
- ADDR_W, 19, address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 8, colour word width.
- ROW_FIRST, 7, first row offset, inclusive.
- ROW_LAST, 22, last row offset, inclusive.
- COL_FIRST, 8, first column offset, inclusive.
- COL_LAST, 22, last column offset, inclusive.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a fill; sampled only in IDLE.
- startaddr  in  ADDR_W  box origin linear address; latched on an accepted start.
- color_in  in  DATA_W  fill colour; latched on an accepted start.
- wr_ready  in  1  framebuffer accepts the current write this cycle.
- wr_en  out  1  write request valid.
- wr_addr  out  ADDR_W  pixel address of the current write.
- wr_data  out  DATA_W  colour of the current write.
- busy  out  1  high in DRAW and DONE.
- done  out  1  one-cycle pulse when the fill completes.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - State is IDLE.
  - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
  - Internal row/column counters and the row base are cleared.
- States: IDLE, DRAW, DONE.
- IDLE:
  - start=1 at a rising edge latches startaddr and color_in.
  - Sets row_base = startaddr + ROW_FIRST*SCREEN_W, row = ROW_FIRST, col = COL_FIRST.
  - Moves to DRAW.
- DRAW:
  - wr_en=1, wr_addr = row_base + col, wr_data = latched colour. All outputs are registered.
  - A write is consumed only on a cycle with wr_en=1 and wr_ready=1.
  - While wr_ready=0, wr_addr and wr_data hold stable and wr_en stays high. Requests are never dropped.
  - After a consumed write:
    - If col < COL_LAST: col+1.
    - Else if row < ROW_LAST: col = COL_FIRST, row+1, row_base += SCREEN_W.
    - Else (last pixel): go to DONE.
  - Row base is updated by addition only; no multiplier in the datapath.
- DONE:
  - wr_en=0, done=1 for exactly one cycle, busy=1.
  - Next state is IDLE.
- Totals:
  - Writes per fill: (ROW_LAST-ROW_FIRST+1)*(COL_LAST-COL_FIRST+1) = 16*15 = 240.
  - Latency: first wr_en in the cycle after start is accepted.
  - With wr_ready held high, wr_en is high for 240 consecutive cycles and done pulses on the cycle after the last write.
- Boundary conditions:
  - start while busy is ignored. Latched address and colour are unaffected, and no queueing occurs.
  - Changes to startaddr or color_in after acceptance have no effect.
  - Address sums wrap modulo 2^ADDR_W. There is no screen-bounds check; clipping belongs to the caller.
  - start=1 in the DONE cycle is ignored. start held high through DONE is accepted in the following IDLE cycle.
  - Reset asserted mid-fill returns to the reset state immediately: wr_en drops asynchronously and no done pulse is produced.
  - busy = (state != IDLE).

Test Plan:
- Basic fill: startaddr=0, color_in=8'h3C, wr_ready=1, start pulsed at edge 0.
  - Response: wr_en high for 240 cycles.
  - First wr_addr=4488, then 4489 … 4502.
  - Row step: 4502 → 5128.
  - Last wr_addr=14102.
  - wr_data=8'h3C throughout.
  - Single done pulse on the next cycle; busy falls after it.
- Backpressure: same stimulus with wr_ready toggling 1,0,0,1,…
  - Response: exactly 240 handshakes, same address sequence, no gaps or repeats.
  - Outputs stable during stalls.
- Start while busy: a second start with startaddr=1000 and color 8'hFF mid-fill.
  - Response: the sequence stays based on the first request; exactly one done pulse.
- Reset mid-fill: assert reset after 50 writes.
  - Response: wr_en/busy/done go 0 immediately.
  - A new start after release begins again at startaddr+4488.
- Wrap-around: startaddr = 2^19-100.
  - Response: first wr_addr = (2^19-100+4488) mod 2^19 = 4388.
  - Subsequent addresses also wrap modulo 2^19.
- Back-to-back: start held high continuously.
  - Response: fill, done, one IDLE cycle, then the next fill starts. 240 writes per fill.
